// File: rtl/tt_loader_pkg.sv
// Shared types and helpers for the byte-serial program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_loader_pkg;

    // Width of the running modular checksum.
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Bytes per instruction word.
    function automatic int bpw(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/tt_byte_packer.sv
// Packs accepted bytes big-endian into DATA_W-bit words; word_vld pulses after the last byte.
// Latency: word_vld/word_dat valid the cycle after the BPW-th byte; held until word_ack.
// Backpressure: none internally; the caller must not push bytes while word_vld is pending.
// Ports: clk/rst_n/ena, clr (drop partial word), byte_vld/byte_dat in, word_ack in, word_vld/word_dat out.
module tt_byte_packer
    import tt_loader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    input  logic              word_ack,
    output logic              word_vld,
    output logic [DATA_W-1:0] word_dat
);

    localparam int BPW   = bpw(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift_nxt;

    // Shift left so the first byte of a word ends up in the top byte lane.
    generate
        if (DATA_W == 8) begin : g_one_byte
            assign shift_nxt = byte_dat;
        end else begin : g_multi_byte
            assign shift_nxt = {word_dat[DATA_W-9:0], byte_dat};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            word_dat <= '0;
            word_vld <= 1'b0;
        end else if (ena) begin
            if (clr) begin
                cnt      <= '0;
                word_dat <= '0;
                word_vld <= 1'b0;
            end else begin
                if (word_ack) begin
                    word_vld <= 1'b0;
                end
                if (byte_vld) begin
                    word_dat <= shift_nxt;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        word_vld <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tt_prog_loader.sv
// Byte-serial program loader: packs a byte stream into instruction words, verifies a checksum, releases the core.
// Latency: one mem_we cycle after each word's last byte; done/cpu_rst_n rise the cycle after the check byte.
// Backpressure: byte_ready drops while a packed word awaits its write, outside LOAD/CHECK, and when ena=0.
// Ports: start/len command, byte_in/byte_valid/byte_ready stream, mem_we/mem_addr/mem_wdata memory port,
//        cpu_rst_n/busy/done/err status (registered), sum_q debug checksum.
module tt_prog_loader
    import tt_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CSUM_W-1:0] sum_q
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic              word_vld;
    logic [DATA_W-1:0] word_dat;
    logic              byte_acc;
    logic              pack_clr;
    logic              last_word;
    logic              len_bad;
    logic [CSUM_W-1:0] sum_nxt;

    // {busy, done, err, cpu_rst_n} for the state being entered, so all four
    // registered outputs switch together with the state register.
    function automatic logic [3:0] outs(input state_t s);
        case (s)
            LOAD, CHECK: outs = 4'b1000;
            RUN:         outs = 4'b0101;
            ERROR:       outs = 4'b0010;
            default:     outs = 4'b0000;
        endcase
    endfunction

    // Holding off bytes while a word is pending keeps the check byte from
    // being consumed as data in the cycle the final word is written.
    assign byte_ready = ena & (((state == LOAD) & ~word_vld) | (state == CHECK));
    // start has priority: a byte presented alongside it is dropped.
    assign byte_acc   = byte_valid & byte_ready & ~start;
    assign pack_clr   = ena & start;
    assign mem_we     = ena & (state == LOAD) & word_vld;
    assign mem_wdata  = word_dat;
    assign last_word  = ({1'b0, mem_addr} == (len_q - ONE_L));
    assign len_bad    = (len == '0) || (len > DEPTH_L);
    assign sum_nxt    = sum_q + byte_in;

    tt_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clr      (pack_clr),
        .byte_vld (byte_acc & (state == LOAD)),
        .byte_dat (byte_in),
        .word_ack (mem_we),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                       <= IDLE;
            len_q                       <= '0;
            mem_addr                    <= '0;
            sum_q                       <= '0;
            {busy, done, err, cpu_rst_n} <= 4'b0000;
        end else if (ena) begin
            if (start) begin
                // Valid from every state: restarts an in-flight load or a running core.
                len_q    <= len;
                mem_addr <= '0;
                sum_q    <= '0;
                if (len_bad) begin
                    state                       <= ERROR;
                    {busy, done, err, cpu_rst_n} <= outs(ERROR);
                end else begin
                    state                       <= LOAD;
                    {busy, done, err, cpu_rst_n} <= outs(LOAD);
                end
            end else begin
                case (state)
                    LOAD: begin
                        if (byte_acc) begin
                            sum_q <= sum_nxt;
                        end
                        if (mem_we) begin
                            // The last address is not advanced so a full-depth load never wraps.
                            if (last_word) begin
                                state                       <= CHECK;
                                {busy, done, err, cpu_rst_n} <= outs(CHECK);
                            end else begin
                                mem_addr <= mem_addr + ADDR_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (byte_acc) begin
                            sum_q <= sum_nxt;
                            if (sum_nxt == '0) begin
                                state                       <= RUN;
                                {busy, done, err, cpu_rst_n} <= outs(RUN);
                            end else begin
                                state                       <= ERROR;
                                {busy, done, err, cpu_rst_n} <= outs(ERROR);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_prog_loader.sv
// Bench for tt_prog_loader: directed sequence with random payloads, compared to a byte-list model.
module tb_tt_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [8:0]  len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  sum_q;

    typedef logic [7:0] bq_t[$];
    typedef struct { int addr; int data; } wr_t;

    wr_t wr_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    tt_prog_loader #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .len        (len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sum_q      (sum_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write as seen at the clock edge.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_q.push_back('{int'(mem_addr), int'(mem_wdata)});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic do_start(input int l, input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        start      = 1'b1;
        len        = 9'(l);
        byte_valid = with_byte;
        byte_in    = b;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Present one byte until it is accepted (optionally with random valid gaps).
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit acc = 1'b0;
        int t   = 0;
        while (!acc && t < 300) begin
            @(negedge clk);
            byte_in    = b;
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1 acc = byte_valid && byte_ready && ena;
            @(posedge clk);
            t++;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // Five disabled cycles with valid and an illegal start presented: nothing may move.
    task automatic ena_hold();
        @(negedge clk);
        ena        = 1'b0;
        byte_valid = 1'b1;
        start      = 1'b1;
        len        = 9'd0;
        repeat (5) begin
            #1;
            chk("ena0_byte_ready", 32'(byte_ready), 32'd0);
            chk("ena0_mem_we", 32'(mem_we), 32'd0);
            @(negedge clk);
        end
        ena        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Stream an image and its checksum, then compare writes to the expected word list.
    task automatic load_image(input bq_t bytes, input bit rnd, input bit bad, input int hold_at);
        logic [7:0] s;
        logic [7:0] cs;
        int         n;
        s = 8'd0;
        n = bytes.size() / 2;
        foreach (bytes[i]) begin
            send_byte(bytes[i], rnd);
            s = s + bytes[i];
            if (i == 0) begin
                #1;
                chk("load_busy", 32'(busy), 32'd1);
                chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            end
            if (hold_at >= 0 && (i == hold_at || i == hold_at + 3)) ena_hold();
        end
        cs = 8'd0 - s;
        if (bad) cs = cs + 8'd1;
        send_byte(cs, rnd);
        idle(3);
        chk("write_count", 32'(wr_q.size()), 32'(n));
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            chk($sformatf("write_addr[%0d]", k), 32'(wr_q[k].addr), 32'(k));
            chk($sformatf("write_data[%0d]", k), 32'(wr_q[k].data), {16'd0, bytes[2*k], bytes[2*k+1]});
        end
    endtask

    task automatic chk_status(input string tag, input bit b, input bit d, input bit e, input bit c);
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
    endtask

    initial begin
        bq_t img;
        rst_n      = 1'b0;
        ena        = 1'b1;
        start      = 1'b0;
        len        = 9'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;

        // Reset state
        #25;
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_byte_ready", 32'(byte_ready), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_sum_q", 32'(sum_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Nominal two-word load
        wr_q.delete();
        do_start(2, 1'b0, 8'd0);
        img = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        load_image(img, 1'b0, 1'b0, -1);
        chk_status("nominal", 1'b0, 1'b1, 1'b0, 1'b1);

        // 2. Bad checksum; also checks the restart out of RUN
        wr_q.delete();
        do_start(2, 1'b0, 8'd0);
        #1;
        chk_status("run_restart", 1'b1, 1'b0, 1'b0, 1'b0);
        load_image(img, 1'b0, 1'b1, -1);
        chk_status("bad_csum", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3. Length bounds
        wr_q.delete();
        do_start(0, 1'b0, 8'd0);
        #1;
        chk_status("len0", 1'b0, 1'b0, 1'b1, 1'b0);
        do_start(257, 1'b0, 8'd0);
        #1;
        chk_status("len257", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("len_bad_writes", 32'(wr_q.size()), 32'd0);
        do_start(256, 1'b0, 8'd0);
        img.delete();
        repeat (512) img.push_back(8'($urandom));
        load_image(img, 1'b0, 1'b0, -1);
        if (wr_q.size() > 0) chk("full_last_addr", 32'(wr_q[wr_q.size()-1].addr), 32'd255);
        chk_status("full", 1'b0, 1'b1, 1'b0, 1'b1);

        // 4. Random valid gaps and ena holds (after a word completes and mid-word)
        wr_q.delete();
        do_start(8, 1'b0, 8'd0);
        img.delete();
        repeat (16) img.push_back(8'($urandom));
        load_image(img, 1'b1, 1'b0, 3);
        chk_status("backpressure", 1'b0, 1'b1, 1'b0, 1'b1);

        // 5. Restart mid-load, with a byte presented alongside start
        do_start(2, 1'b0, 8'd0);
        repeat (3) send_byte(8'($urandom), 1'b0);
        idle(1);
        wr_q.delete();
        do_start(1, 1'b1, 8'hEE);
        img = '{8'h55, 8'h66};
        load_image(img, 1'b0, 1'b0, -1);
        chk_status("restart", 1'b0, 1'b1, 1'b0, 1'b1);

        // 6. Asynchronous reset mid-load
        do_start(2, 1'b0, 8'd0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_status("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("async_rst_mem_we", 32'(mem_we), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("async_rst_sum_q", 32'(sum_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        #1;
        chk_status("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_byte_ready", 32'(byte_ready), 32'd0);
        wr_q.delete();
        do_start(1, 1'b0, 8'd0);
        img.delete();
        repeat (2) img.push_back(8'($urandom));
        load_image(img, 1'b1, 1'b0, -1);
        chk_status("post_rst_load", 1'b0, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
